// File: rtl/cheby_pkg.sv
// cheby_pkg: Q1.15 format constants, sequencer state enum and accumulator width derivation for cheby_series_mac
package cheby_pkg;
  localparam int FRAC_BITS = 15;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;
  typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_e;
  function automatic int acc_width(input int n_terms, input int data_w);
    return 2 * data_w + $clog2(n_terms);
  endfunction
endpackage

// File: rtl/cheby_round_sat.sv
// cheby_round_sat: combinational acc -> Q1.15 result (shift by FRAC_BITS, optional round half up via CHEBY_MAC_ROUND_EN) with saturation; ports acc in, result/sat out
module cheby_round_sat
  import cheby_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] result,
  output logic                     sat
);
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;
`ifdef CHEBY_MAC_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_BITS - 1);
  assign biased = acc + HALF;
`else
  assign biased = acc;
`endif
  assign shifted = biased >>> FRAC_BITS;
  // fits in DATA_W only when every bit above the result sign bit equals the sign
  assign sat = shifted[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){shifted[ACC_W-1]}};
  assign result = sat ? (shifted[ACC_W-1] ? DATA_W'(Q_MIN) : DATA_W'(Q_MAX)) : shifted[DATA_W-1:0];
endmodule

// File: rtl/cheby_series_mac.sv
// cheby_series_mac: walks the T_k ROM, pairs each term with streamed weight w_k, returns saturated Q1.15 sum(w_k*T_k); ports: clk/reset, c_start/o_busy/o_done, weight valid/ready stream, ROM controls, o_result/o_result_valid/o_sat; option CHEBY_MAC_ROUND_EN
module cheby_series_mac
  import cheby_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = acc_width(N_TERMS, DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_start,
  output logic              o_busy,
  output logic              o_done,
  input  logic [DATA_W-1:0] i_weight,
  input  logic              i_weight_valid,
  output logic              o_weight_ready,
  output logic [ADDR_W-1:0] o_rom_address,
  output logic              c_rom_read_en,
  output logic              c_rom_ce,
  output logic              c_rom_tri_output,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_result,
  output logic              o_result_valid,
  output logic              o_sat
);
  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum;
  logic signed [DATA_W-1:0]  t_q, t_d, w_q, w_d;
  logic [DATA_W-1:0]         result_q, result_d, rs_result;
  logic                      sat_q, sat_d, rs_sat;
  logic signed [2*DATA_W-1:0] prod;
  logic                      last;
  assign prod    = t_q * w_q;
  assign acc_sum = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign last    = k_q == ADDR_W'(N_TERMS - 1);
  // the result register loads while entering DONE, so it sees the sum including the last term
  cheby_round_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_round_sat (
    .acc    (acc_sum),
    .result (rs_result),
    .sat    (rs_sat)
  );
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    t_d      = t_q;
    w_d      = w_q;
    result_d = result_q;
    sat_d    = sat_q;
    unique case (state_q)
      IDLE: if (c_start) begin
        state_d = FETCH;
        k_d     = '0;
        acc_d   = '0;
      end
      FETCH: if (i_weight_valid) begin
        t_d     = i_rom_data;
        w_d     = i_weight;
        state_d = MAC;
      end
      MAC: begin
        acc_d    = acc_sum;
        state_d  = last ? DONE : FETCH;
        k_d      = last ? k_q : k_q + 1'b1;
        result_d = last ? rs_result : result_q;
        sat_d    = last ? rs_sat : sat_q;
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      t_q      <= '0;
      w_q      <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      t_q      <= t_d;
      w_q      <= w_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end
  assign o_busy           = state_q != IDLE;
  assign o_done           = state_q == DONE;
  assign o_result_valid   = state_q == DONE;
  assign o_weight_ready   = state_q == FETCH;
  assign c_rom_read_en    = state_q == FETCH;
  assign c_rom_ce         = state_q == FETCH || state_q == MAC;
  assign c_rom_tri_output = !(state_q == FETCH || state_q == MAC);
  assign o_rom_address    = k_q;
  assign o_result         = result_q;
  assign o_sat            = sat_q;
endmodule
